// File: rtl/iob_fifo_wr_arbiter.sv
// iob_fifo_wr_arbiter
// Frame-granular round-robin arbiter sharing the single write port of an
// iob_fifo_async between N requesters. A granted requester owns the port until
// it delivers the beat flagged last. A watchdog frees the port if the owner
// stops offering beats, and a wrapping counter tallies completed frames.
//
// Ports
//   clk_i          FIFO write clock
//   arst_n_i       asynchronous reset, active-low
//   cke_i          clock enable; low freezes state and forces ready/write low
//   rst_i          synchronous clear, active-high, qualified by cke_i
//   req_valid_i    per-requester beat valid                      [N]
//   req_data_i     per-requester data, slice k*DATA_W+:DATA_W    [N*DATA_W]
//   req_last_i     per-requester last-beat flag                  [N]
//   req_ready_o    per-requester beat accept                     [N]
//   fifo_w_en_o    FIFO write enable
//   fifo_w_data_o  FIFO write data                               [DATA_W]
//   fifo_w_full_i  FIFO full
//   fifo_w_level_i FIFO write-side fill level                    [ADDR_W+1]
//   grant_o        one-hot grant, zero while idle                [N]
//   busy_o         high while a frame is being transferred
//   timeout_o      one-cycle pulse when the watchdog drops a grant
//   frames_o       completed-frame count, wraps                  [CNT_W]
module iob_fifo_wr_arbiter #(
  parameter int N        = 2,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int MIN_FREE = 4,
  parameter int TIMEOUT  = 64,
  parameter int CNT_W    = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  cke_i,
  input  logic                  rst_i,
  input  logic [N-1:0]          req_valid_i,
  input  logic [N*DATA_W-1:0]   req_data_i,
  input  logic [N-1:0]          req_last_i,
  output logic [N-1:0]          req_ready_o,
  output logic                  fifo_w_en_o,
  output logic [DATA_W-1:0]     fifo_w_data_o,
  input  logic                  fifo_w_full_i,
  input  logic [ADDR_W:0]       fifo_w_level_i,
  output logic [N-1:0]          grant_o,
  output logic                  busy_o,
  output logic                  timeout_o,
  output logic [CNT_W-1:0]      frames_o
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Highest fill level that still leaves MIN_FREE words for a new frame.
  localparam logic [ADDR_W:0] LVL_MAX = (ADDR_W + 1)'((2 ** ADDR_W) - MIN_FREE);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    g_q;
  logic [IDX_W-1:0]    p_q;
  logic [TO_W-1:0]     idle_q;
  logic [CNT_W-1:0]    frames_q;
  logic [N-1:0]        grant_q;
  logic                timeout_q;

  logic                space_ok_s;
  logic                pick_found_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic [IDX_W-1:0]    cand_s;
  logic [IDX_W-1:0]    next_g_s;
  logic [N-1:0]        ready_s;
  logic                accept_s;
  logic [DATA_W-1:0]   data_s;

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign space_ok_s = (fifo_w_level_i <= LVL_MAX);
  assign next_g_s   = (int'(g_q) == (N - 1)) ? '0 : g_q + IDX_W'(1);

  // Round-robin search: first valid requester starting at the pointer.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = '0;
    for (int i = 0; i < N; i++) begin
      cand_s = IDX_W'((int'(p_q) + i) % N);
      if (!pick_found_s && req_valid_i[cand_s]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Ready only for the owner, only while transferring and the FIFO has room.
  always_comb begin
    ready_s = '0;
    if ((state_q == ST_XFER) && cke_i && !rst_i && !fifo_w_full_i) begin
      ready_s[g_q] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign accept_s = |(ready_s & req_valid_i);

  // Write data follows the current grant index with no added latency.
  always_comb begin
    data_s = '0;
    for (int k = 0; k < N; k++) begin
      if (g_q == IDX_W'(k)) begin
        data_s = req_data_i[k*DATA_W +: DATA_W];
      end else begin
        data_s = data_s;
      end
    end
  end

  // Arbitration FSM with watchdog, frame counter and registered status.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= ST_IDLE;
      g_q       <= '0;
      p_q       <= '0;
      idle_q    <= '0;
      frames_q  <= '0;
      grant_q   <= '0;
      timeout_q <= 1'b0;
    end else if (cke_i) begin
      if (rst_i) begin
        state_q   <= ST_IDLE;
        g_q       <= '0;
        p_q       <= '0;
        idle_q    <= '0;
        frames_q  <= '0;
        grant_q   <= '0;
        timeout_q <= 1'b0;
      end else begin
        timeout_q <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (pick_found_s && space_ok_s) begin
              state_q <= ST_XFER;
              g_q     <= pick_idx_s;
              grant_q <= onehot(pick_idx_s);
              idle_q  <= '0;
            end
          end
          ST_XFER: begin
            if (accept_s) begin
              idle_q <= '0;
              if (req_last_i[g_q]) begin
                frames_q <= frames_q + CNT_W'(1);
                p_q      <= next_g_s;
                state_q  <= ST_IDLE;
                grant_q  <= '0;
              end
            end else if ((TIMEOUT > 0) && (idle_q == TO_W'(TIMEOUT - 1))) begin
              // This is the TIMEOUT-th consecutive cycle without a beat.
              timeout_q <= 1'b1;
              p_q       <= next_g_s;
              state_q   <= ST_IDLE;
              grant_q   <= '0;
              idle_q    <= '0;
            end else if (TIMEOUT > 0) begin
              idle_q <= idle_q + TO_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            grant_q <= '0;
          end
        endcase
      end
    end
  end

  assign req_ready_o   = ready_s;
  assign fifo_w_en_o   = accept_s;
  assign fifo_w_data_o = data_s;
  assign grant_o       = grant_q;
  assign busy_o        = (state_q == ST_XFER);
  assign timeout_o     = timeout_q;
  assign frames_o      = frames_q;

endmodule

// File: tb/tb_iob_fifo_wr_arbiter.sv
module tb_iob_fifo_wr_arbiter;

  localparam int N        = 2;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int MIN_FREE = 4;
  localparam int TIMEOUT  = 8;
  localparam int CNT_W    = 16;

  logic                clk;
  logic                arst_n;
  logic                cke;
  logic                rst;
  logic [N-1:0]        req_valid;
  logic [N*DATA_W-1:0] req_data;
  logic [N-1:0]        req_last;
  logic [N-1:0]        req_ready;
  logic                w_en;
  logic [DATA_W-1:0]   w_data;
  logic                w_full;
  logic [ADDR_W:0]     w_level;
  logic [N-1:0]        grant;
  logic                busy;
  logic                timeout;
  logic [CNT_W-1:0]    frames;

  iob_fifo_wr_arbiter #(
    .N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MIN_FREE(MIN_FREE),
    .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .rst_i(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .fifo_w_en_o(w_en), .fifo_w_data_o(w_data),
    .fifo_w_full_i(w_full), .fifo_w_level_i(w_level), .grant_o(grant),
    .busy_o(busy), .timeout_o(timeout), .frames_o(frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int en_seen  = 0;

  // Reference model: who owns the port, where the search starts, how long the
  // owner has been silent, and how many frames have finished.
  int m_busy, m_g, m_p, m_idle, m_frames, m_tout;

  // Requester sources: beats left in the current frame, sequence number of the
  // next beat, and cycles left before the source offers data again.
  int rem [N];
  int seq [N];
  int pause [N];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_p = 0; m_idle = 0; m_frames = 0; m_tout = 0;
  endtask

  task automatic drive_sources();
    for (int k = 0; k < N; k++) begin
      req_valid[k] = (rem[k] > 0) && (pause[k] == 0);
      req_last[k]  = (rem[k] == 1);
      req_data[k*DATA_W +: DATA_W] = {4'(k), 12'h000, 16'(seq[k])};
      if (pause[k] > 0) pause[k]--;
    end
  endtask

  // One clock: check outputs against the model, then advance model and sources.
  task automatic step();
    logic [N-1:0] er;
    logic         ee;
    logic [N-1:0] eg;
    int           acc_k;
    int           found;
    @(negedge clk);
    er = '0;
    if (m_busy != 0 && cke && !rst && !w_full) er[m_g] = 1'b1;
    ee = er[m_g] & req_valid[m_g];
    eg = '0;
    if (m_busy != 0) eg[m_g] = 1'b1;
    check_val("grant", 64'(grant), 64'(eg));
    check_val("busy", 64'(busy), 64'(m_busy));
    check_val("timeout", 64'(timeout), 64'(m_tout));
    check_val("frames", 64'(frames), 64'(m_frames));
    check_val("ready", 64'(req_ready), 64'(er));
    check_val("w_en", 64'(w_en), 64'(ee));
    if (ee) check_val("w_data", 64'(w_data), 64'(req_data[m_g*DATA_W +: DATA_W]));
    if (w_en) en_seen++;
    acc_k = m_g;
    if (cke) begin
      if (rst) model_reset();
      else begin
        m_tout = 0;
        if (m_busy == 0) begin
          found = 0;
          if (int'(w_level) <= (2 ** ADDR_W) - MIN_FREE) begin
            for (int i = 0; i < N; i++) begin
              if (found == 0 && req_valid[(m_p + i) % N]) begin
                found = 1; m_g = (m_p + i) % N; m_busy = 1; m_idle = 0;
              end
            end
          end
        end else if (ee) begin
          m_idle = 0;
          if (req_last[m_g]) begin
            m_frames = (m_frames + 1) % (2 ** CNT_W);
            m_p = (m_g + 1) % N;
            m_busy = 0;
          end
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT) begin
            m_tout = 1; m_busy = 0; m_p = (m_g + 1) % N; m_idle = 0;
          end
        end
      end
    end
    if (ee) begin
      seq[acc_k]++;
      rem[acc_k]--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      drive_sources();
      step();
    end
  endtask

  initial begin
    arst_n = 1'b0; cke = 1'b1; rst = 1'b0; w_full = 1'b0; w_level = '0;
    req_valid = '0; req_last = '0; req_data = '0;
    for (int k = 0; k < N; k++) begin rem[k] = 0; seq[k] = 0; pause[k] = 0; end
    model_reset();
    #12;
    check_val("rst_grant", 64'(grant), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_timeout", 64'(timeout), 64'd0);
    check_val("rst_frames", 64'(frames), 64'd0);
    check_val("rst_ready", 64'(req_ready), 64'd0);
    check_val("rst_en", 64'(w_en), 64'd0);
    @(posedge clk); #1;
    arst_n = 1'b1;

    // 3-beat frame from requester 0.
    rem[0] = 3; en_seen = 0;
    cycles(7);
    check_val("t1_beats", 64'(en_seen), 64'd3);
    check_val("t1_frames", 64'(frames), 64'd1);
    check_val("t1_busy", 64'(busy), 64'd0);

    // Both requesters streaming 2-beat frames: grants alternate.
    en_seen = 0;
    repeat (12) begin
      for (int k = 0; k < N; k++) if (rem[k] == 0) rem[k] = 2;
      cycles(1);
    end
    check_val("t2_frames", 64'(frames), 64'd5);
    check_val("t2_beats", 64'(en_seen), 64'd8);
    rem[0] = 0; rem[1] = 0;

    // Level too high to start a frame, then just low enough.
    w_level = 5'd13; rem[1] = 2;
    cycles(3);
    check_val("t3_withheld", 64'(grant), 64'd0);
    w_level = 5'd12;
    cycles(1);
    check_val("t3_granted", 64'(grant), 64'h2);
    w_level = '0;
    cycles(3);

    // FIFO full for 5 cycles mid-frame.
    rem[0] = 4;
    cycles(2);
    w_full = 1'b1; en_seen = 0;
    cycles(5);
    check_val("t4_stall_en", 64'(en_seen), 64'd0);
    check_val("t4_hold", 64'(grant), 64'h1);
    w_full = 1'b0;
    cycles(4);
    check_val("t4_frames", 64'(frames), 64'd7);

    // Watchdog: one beat then silence.
    rem[0] = 3;
    cycles(2);
    pause[0] = 20; rem[1] = 1;
    cycles(8);
    check_val("t5_pulse", 64'(timeout), 64'd1);
    check_val("t5_drop", 64'(grant), 64'd0);
    check_val("t5_frames", 64'(frames), 64'd7);
    cycles(1);
    check_val("t5_next", 64'(grant), 64'h2);
    cycles(20);

    // Async reset in the middle of a frame.
    rem[0] = 3; rem[1] = 3;
    cycles(2);
    drive_sources();
    #2 arst_n = 1'b0;
    #1;
    check_val("t6_grant", 64'(grant), 64'd0);
    check_val("t6_busy", 64'(busy), 64'd0);
    check_val("t6_ready", 64'(req_ready), 64'd0);
    check_val("t6_en", 64'(w_en), 64'd0);
    check_val("t6_frames", 64'(frames), 64'd0);
    model_reset();
    @(posedge clk); #1;
    arst_n = 1'b1;
    cycles(1);
    check_val("t6_first", 64'(grant), 64'h1);

    // Randomized traffic.
    repeat (3000) begin
      cke     = ($urandom_range(0, 19) != 0);
      rst     = ($urandom_range(0, 99) == 0);
      w_full  = ($urandom_range(0, 9) == 0);
      w_level = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(0, 10)) : 5'($urandom_range(11, 16));
      for (int k = 0; k < N; k++) begin
        if (rem[k] == 0 && $urandom_range(0, 3) == 0) rem[k] = $urandom_range(1, 4);
        if (pause[k] == 0) begin
          if ($urandom_range(0, 49) == 0) pause[k] = 12;
          else if ($urandom_range(0, 5) == 0) pause[k] = 1;
        end
      end
      cycles(1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
